// File: rtl/redun_pkg.sv
// Shared defaults and types for the redundant-to-binary conversion stage.
package redun_pkg;

    localparam int DEF_NUM_WRDS = 65;
    localparam int DEF_WRD_BITS = 16;
    localparam int DEF_RED_BITS = 1;
    localparam int DIG_BITS     = DEF_WRD_BITS + DEF_RED_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    typedef logic [DIG_BITS-1:0] dig_t;

endpackage

// File: rtl/redun_digit_add.sv
// One digit of serial carry propagation: redundant digit plus incoming carry,
// split into the binary low word and the carry into the next digit.
module redun_digit_add
    import redun_pkg::*;
#(
    parameter int WRD_BITS = DEF_WRD_BITS,
    parameter int RED_BITS = DEF_RED_BITS
) (
    input  logic [WRD_BITS+RED_BITS-1:0] dig,
    input  logic [RED_BITS:0]            carry_in,
    output logic [WRD_BITS-1:0]          sum_lo,
    output logic [RED_BITS:0]            carry_out
);

    localparam int DW = WRD_BITS + RED_BITS;

    logic [DW:0] sum;

    // One extra bit of headroom holds digit + carry without loss.
    always_comb begin
        sum       = (DW+1)'(dig) + (DW+1)'(carry_in);
        sum_lo    = sum[WRD_BITS-1:0];
        carry_out = sum[DW:WRD_BITS];
    end

endmodule

// File: rtl/redun_to_bin.sv
// Redundant (carry-save-per-digit) to binary converter, one digit per cycle.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Input side: i_val must be held until o_rdy; o_rdy is high only
// in IDLE. Output side: o_val stays high in DONE with o_dat/o_carry/o_ovf
// stable until i_rdy. o_rdy and o_val are registered and never both high.
module redun_to_bin
    import redun_pkg::*;
#(
    parameter int NUM_WRDS = DEF_NUM_WRDS,
    parameter int WRD_BITS = DEF_WRD_BITS,
    parameter int RED_BITS = DEF_RED_BITS,
    parameter int CNT_BITS = $clog2(NUM_WRDS+1)
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic [NUM_WRDS*(WRD_BITS+RED_BITS)-1:0] i_dat,
    input  logic                                   i_val,
    output logic                                   o_rdy,
    output logic [NUM_WRDS*WRD_BITS-1:0]           o_dat,
    output logic [RED_BITS:0]                      o_carry,
    output logic                                   o_ovf,
    output logic                                   o_val,
    input  logic                                   i_rdy
);

    localparam int DW = WRD_BITS + RED_BITS;
    localparam int CW = RED_BITS + 1;
    localparam int OW = NUM_WRDS * WRD_BITS;
    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(NUM_WRDS - 1);

    fsm_t                   state;
    fsm_t                   state_nxt;
    logic [CNT_BITS-1:0]    cnt;
    logic [CW-1:0]          carry;
    logic [CW-1:0]          carry_nxt;
    logic [NUM_WRDS*DW-1:0] shadow;
    logic [WRD_BITS-1:0]    sum_lo;
    logic                   accept;
    logic                   last;

    // The shadow register shifts down one digit per cycle, so the single
    // adder always works on its lowest digit.
    redun_digit_add #(
        .WRD_BITS (WRD_BITS),
        .RED_BITS (RED_BITS)
    ) u_add (
        .dig       (shadow[DW-1:0]),
        .carry_in  (carry),
        .sum_lo    (sum_lo),
        .carry_out (carry_nxt)
    );

    // Next-state decode plus accept/last strobes for the datapath.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_val && o_rdy) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST_CNT) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (i_rdy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered handshake flags, derived from the next state so they line up
    // with the state they describe; o_rdy stays low until the first edge after reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rdy <= 1'b0;
            o_val <= 1'b0;
        end else begin
            o_rdy <= (state_nxt == IDLE);
            o_val <= (state_nxt == DONE);
        end
    end

    // Datapath: latch on accept, then ripple one digit per RUN cycle. The
    // result word shifts in from the top, so after NUM_WRDS steps digit 0
    // sits at the bottom; partial contents during RUN are not meaningful.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shadow  <= '0;
            carry   <= '0;
            cnt     <= '0;
            o_dat   <= '0;
            o_carry <= '0;
            o_ovf   <= 1'b0;
        end else if (accept) begin
            shadow <= i_dat;
            carry  <= '0;
            cnt    <= '0;
        end else if (state == RUN) begin
            shadow <= shadow >> DW;
            carry  <= carry_nxt;
            cnt    <= cnt + CNT_BITS'(1);
            o_dat  <= {sum_lo, o_dat[OW-1:WRD_BITS]};
            if (last) begin
                o_carry <= carry_nxt;
                o_ovf   <= |carry_nxt;
            end
        end
    end

endmodule

// File: tb/tb_redun_to_bin.sv
// Directed and random checks of redun_to_bin with 4 digits of 16+1 bits.
module tb_redun_to_bin;

    localparam int NW    = 4;
    localparam int WB    = 16;
    localparam int RB    = 1;
    localparam int DW    = WB + RB;
    localparam int DAT_W = NW * DW;
    localparam int OUT_W = NW * WB;
    localparam int EXP_W = OUT_W + RB + 1;

    logic             clk;
    logic             rst_n;
    logic [DAT_W-1:0] i_dat;
    logic             i_val;
    logic             o_rdy;
    logic [OUT_W-1:0] o_dat;
    logic [RB:0]      o_carry;
    logic             o_ovf;
    logic             o_val;
    logic             i_rdy;

    logic [EXP_W-1:0] exp_q[$];
    int               n_checks;
    int               n_fail;
    int               tx_cnt;
    int               rx_cnt;
    bit               rnd_done;

    redun_to_bin #(
        .NUM_WRDS (NW),
        .WRD_BITS (WB),
        .RED_BITS (RB)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_dat   (i_dat),
        .i_val   (i_val),
        .o_rdy   (o_rdy),
        .o_dat   (o_dat),
        .o_carry (o_carry),
        .o_ovf   (o_ovf),
        .o_val   (o_val),
        .i_rdy   (i_rdy)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: integer value of sum(digit_i * 2^(16*i)), carry above bit 63.
    function automatic logic [EXP_W-1:0] ref_val(input logic [DAT_W-1:0] d);
        logic [EXP_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < NW; i++) begin
            acc = acc + (EXP_W'(d[i*DW +: DW]) << (WB*i));
        end
        return acc;
    endfunction

    function automatic logic [DAT_W-1:0] pack4(input logic [DW-1:0] d3, input logic [DW-1:0] d2,
                                              input logic [DW-1:0] d1, input logic [DW-1:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    function automatic logic [DAT_W-1:0] junk();
        return DAT_W'({$urandom(), $urandom(), $urandom()});
    endfunction

    // Scoreboard: each output consumed (o_val && i_rdy) pops one expected value.
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (rst_n && o_val && i_rdy) begin
            check_val("out_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                rx_cnt++;
                check_val("o_dat", o_dat, e[OUT_W-1:0]);
                check_val("o_carry", o_carry, e[EXP_W-1:OUT_W]);
                check_val("o_ovf", o_ovf, |e[EXP_W-1:OUT_W]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Raises i_val and holds it until o_rdy; returns #1 after the accept edge.
    task automatic send(input logic [DAT_W-1:0] d, input logic [EXP_W-1:0] e, input bit push);
        int n;
        @(negedge clk);
        i_val = 1'b1;
        i_dat = d;
        n = 0;
        while (!o_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val("accept_wait", n < 200, 1);
        if (n < 200 && push) begin
            exp_q.push_back(e);
            tx_cnt++;
        end
        @(posedge clk);
        #1;
        i_val = 1'b0;
        i_dat = junk();
    endtask

    // Counts edges from the accept edge until o_val is seen.
    task automatic wait_lat(input string tag);
        int n;
        n = 0;
        while (!o_val && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val(tag, n, NW);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [DAT_W-1:0] d;
        rst_n    = 1'b0;
        i_val    = 1'b0;
        i_dat    = '0;
        i_rdy    = 1'b1;
        n_checks = 0;
        n_fail   = 0;
        tx_cnt   = 0;
        rx_cnt   = 0;
        rnd_done = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_rdy", o_rdy, 0);
        check_val("rst_val", o_val, 0);
        check_val("rst_dat", o_dat, 0);
        check_val("rst_carry", o_carry, 0);
        check_val("rst_ovf", o_ovf, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rdy_before_edge", o_rdy, 0);
        @(negedge clk);
        check_val("rdy_after_edge", o_rdy, 1);

        // All digits at maximum: carry 2 propagates into the top.
        send(pack4(17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF), {2'd2, 64'h0001_0001_0000_FFFF}, 1);
        wait_lat("lat_max");
        @(posedge clk);
        #1;
        check_val("val_one_cycle", o_val, 0);

        // Redundant bit of digit 0 becomes bit 16.
        send(pack4(17'h0, 17'h0, 17'h0, 17'h10000), {2'd0, 64'h0000_0000_0001_0000}, 1);
        wait_lat("lat_red0");

        // Carry out of digit 0 ripples through two all-ones digits into digit 3.
        send(pack4(17'h0, 17'h0FFFF, 17'h0FFFF, 17'h10000), {2'd0, 64'h0001_0000_0000_0000}, 1);
        wait_lat("lat_ripple");
        @(posedge clk);
        #1;

        // Backpressure: result must hold while i_rdy is low; i_val is ignored.
        i_rdy = 1'b0;
        send(pack4(17'h0, 17'h1ABCD, 17'h00001, 17'h1FFFF), {2'd0, 64'h0001_ABCD_0002_FFFF}, 1);
        wait_lat("lat_bp");
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            i_val = c[0];
            i_dat = junk();
            @(negedge clk);
            check_val("bp_val", o_val, 1);
            check_val("bp_rdy", o_rdy, 0);
            check_val("bp_dat", o_dat, 64'h0001_ABCD_0002_FFFF);
            check_val("bp_carry", o_carry, 0);
        end
        @(posedge clk);
        #1;
        i_val = 1'b0;
        i_rdy = 1'b1;
        @(posedge clk);
        #1;
        check_val("bp_release_val", o_val, 0);
        check_val("bp_release_rdy", o_rdy, 1);
        repeat (6) @(posedge clk);
        #1;
        check_val("bp_no_ghost", o_val, 0);

        // Reset two cycles into RUN aborts with no partial output.
        send(pack4(17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF), '0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("abort_val", o_val, 0);
        check_val("abort_dat", o_dat, 0);
        check_val("abort_rdy", o_rdy, 0);
        check_val("abort_carry", o_carry, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(pack4(17'h0, 17'h0, 17'h0, 17'h00005), {2'd0, 64'h5}, 1);
        wait_lat("lat_after_abort");

        // Random traffic with random gaps and backpressure.
        fork
            begin
                for (int v = 0; v < 200; v++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    for (int k = 0; k < NW; k++) begin
                        d[k*DW +: DW] = DW'($urandom_range(0, 17'h1FFFF));
                    end
                    send(d, ref_val(d), 1);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    i_rdy = ($urandom_range(0, 3) != 0);
                end
            end
        join
        @(posedge clk);
        #1;
        i_rdy = 1'b1;
        for (int w = 0; w < 100 && exp_q.size() != 0; w++) begin
            @(posedge clk);
        end
        repeat (2) @(posedge clk);
        check_val("queue_drained", exp_q.size(), 0);
        check_val("rx_count", rx_cnt, tx_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
